sha1_scheduler: RTL and testbench
=================================

Name: sha1_scheduler

Overview:
Round-robin arbiter and sequencer that shares one sha1 core between NUM_REQ requesters, each supplying a pre-padded 512-bit block.
- Per job: grants one requester, latches its block, and restarts the core with a one-cycle core_reset pulse.
- Then asserts core_on, waits for core_finish (or a timeout), and returns the digest tagged with the requester id over a valid/ready response channel.
- Sits between the host/bus-side requesters and the single sha1 instance.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
ID_W, 1, width of requester id, equals clog2(NUM_REQ) (minimum 1)
TIMEOUT, 511, max cycles to wait for core_finish after core_on before flagging an error

Ports:
clk  input  1  single clock, rising edge
reset  input  1  synchronous, active-high reset
req_valid  input  NUM_REQ  per-requester request valid; held until accepted
req_ready  output  NUM_REQ  one-hot accept strobe; transfer when req_valid[i] & req_ready[i]
req_message  input  NUM_REQ*512  flattened blocks; requester i at bits [512*i+511 : 512*i]
rsp_valid  output  1  response valid
rsp_ready  input  1  response accept
rsp_id  output  ID_W  index of the requester that owns the response
rsp_digest  output  160  core_digest captured at finish; zero on error
rsp_error  output  1  1 = timeout, digest invalid
busy  output  1  high in every state except IDLE
core_reset  output  1  drives sha1 reset
core_on  output  1  drives sha1 on
core_message  output  512  drives sha1 message_in; stable from CLEAR to end of WAIT
core_digest  input  160  sha1 digest_out
core_finish  input  1  sha1 finish

Behaviour:
Reset (clk and reset: one clock; reset is synchronous and active-high):
- State IDLE; rr pointer 0; all registered outputs 0.
- core_reset = reset OR (state==CLEAR), so the core is held in reset with the scheduler.

States:
- IDLE
  - If any req_valid: winner = first set bit searching from rr pointer upward, wrapping modulo NUM_REQ.
  - req_ready[winner]=1 combinationally, this cycle only.
  - Latch req_message slice into core_message and winner into id register; pointer <= winner+1 mod NUM_REQ; -> CLEAR.
  - No valid: stay IDLE, req_ready all 0.
- CLEAR: core_reset=1 for exactly one cycle; timeout counter <= 0; -> RUN.
- RUN: core_on=1 for one cycle (core leaves INIT and latches core_message); -> WAIT.
- WAIT
  - core_on held 1; counter increments each cycle.
  - core_finish=1: capture core_digest; rsp_error <= 0; -> RESP. This takes priority over a timeout reached in the same cycle.
  - counter==TIMEOUT with no finish: rsp_digest <= 0; rsp_error <= 1; -> RESP.
- RESP
  - rsp_valid=1; rsp_id/rsp_digest/rsp_error held stable until rsp_valid & rsp_ready.
  - On transfer: rsp_valid <= 0; -> IDLE. Earliest next grant is the following cycle.

Handshake and arbitration rules:
- req_ready is never asserted outside IDLE. Requests arriving while busy wait; no queueing.
- Exactly one grant per job. Deassertion of req_valid after acceptance has no effect.
- Fairness: with all requesters continuously valid, grants cycle 0,1,...,NUM_REQ-1,0.
- Latency from accept to rsp_valid = 3 + core compute cycles (+1 capture).
- rsp_ready high while rsp_valid is low is ignored. Back-to-back jobs need no idle cycle beyond IDLE arbitration.
- Reset mid-job: job dropped, no response, pointer returns to 0.

Decomposition:
- Shared package sha1_pkg: BLOCK_W=512, DIGEST_W=160, scheduler state enum (IDLE, CLEAR, RUN, WAIT, RESP), default TIMEOUT.
- Sub-module rr_arbiter: parameterised NUM_REQ, combinational one-hot winner from req vector and pointer, plus pointer update.

Test Plan:
- Bench substitutes a behavioural core stub: finish rises N cycles after on, digest = configurable constant.
- Single request: req_valid=01, block 0x61626380_0...0_00000018, stub digest A9993E36_4706816A_BA3E2571_7850C26C_9CD0D89D, N=250.
  -> req_ready=01 one cycle; core_reset pulse; core_on next cycle; rsp_valid with id=0, that digest, error=0.
- Both valid continuously for 4 jobs, rsp_ready=1 -> rsp_id sequence 0,1,0,1; req_ready never two-hot.
- Stub never finishes, TIMEOUT=511 -> rsp_valid after 511 WAIT cycles with error=1, digest=0; next job still processes normally.
- rsp_ready held 0 for 20 cycles -> rsp fields stable, req_ready stays 0 despite req_valid=11; release -> IDLE then grant.
- Reset asserted in WAIT -> next cycle busy=0, rsp_valid=0, core_reset=1 during reset; following request granted to requester 0.
- finish and timeout coincide (stub N=TIMEOUT) -> error=0, digest captured.

Source files
------------

// File: rtl/sha1_scheduler_pkg.sv
// Shared constants, state encoding and helpers for the sha1 job scheduler.
package sha1_pkg;

   localparam int unsigned BLOCK_W         = 512;
   localparam int unsigned DIGEST_W        = 160;
   localparam int unsigned DEFAULT_TIMEOUT = 511;

   typedef enum logic [2:0] {
      StIdle,
      StClear,
      StRun,
      StWait,
      StResp
   } sched_state_e;

   // Requester id width, never narrower than one bit.
   function automatic int unsigned id_width(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/sha1_scheduler_if.sv
// Requester-side and response-side handshake bundle of the sha1 scheduler.
interface sha1_scheduler_if
   import sha1_pkg::*;
#(
   parameter int unsigned NUM_REQ = 2,
   parameter int unsigned ID_W    = id_width(NUM_REQ)
) ();

   logic [NUM_REQ-1:0]         req_valid;
   logic [NUM_REQ-1:0]         req_ready;
   logic [NUM_REQ*BLOCK_W-1:0] req_message;
   logic                       rsp_valid;
   logic                       rsp_ready;
   logic [ID_W-1:0]            rsp_id;
   logic [DIGEST_W-1:0]        rsp_digest;
   logic                       rsp_error;

   modport master (
      output req_valid, req_message, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_digest, rsp_error
   );

   modport slave (
      input  req_valid, req_message, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_digest, rsp_error
   );

endinterface

// File: rtl/sha1_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first requester at or above the pointer, wrapping.
module rr_arbiter #(
   parameter int unsigned NUM_REQ = 2,
   parameter int unsigned ID_W    = 1
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [ID_W-1:0]    i_ptr,
   output logic [NUM_REQ-1:0] o_grant,
   output logic [ID_W-1:0]    o_winner,
   output logic               o_valid,
   output logic [ID_W-1:0]    o_ptr_next
);

   always_comb begin
      o_grant  = '0;
      o_winner = '0;
      o_valid  = 1'b0;
      // Walk offsets high to low so the nearest requester is written last and wins.
      for (int off = NUM_REQ - 1; off >= 0; off--) begin
         int unsigned idx;
         idx = (int'(i_ptr) + off) % NUM_REQ;
         if (i_req[idx]) begin
            o_winner = ID_W'(idx);
            o_valid  = 1'b1;
         end
      end
      if (o_valid) begin
         o_grant[o_winner] = 1'b1;
      end
      o_ptr_next = (int'(o_winner) == NUM_REQ - 1) ? '0 : o_winner + 1'b1;
   end

endmodule

// File: rtl/sha1_scheduler.sv
// Shares one sha1 core among NUM_REQ requesters: arbitrate, restart core, run, return digest.
module sha1_scheduler
   import sha1_pkg::*;
#(
   parameter int unsigned NUM_REQ = 2,
   parameter int unsigned ID_W    = id_width(NUM_REQ),
   parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic                i_clk,
   input  logic                i_reset,
   sha1_scheduler_if.slave     io_bus,
   output logic                o_busy,
   output logic                o_core_reset,
   output logic                o_core_on,
   output logic [BLOCK_W-1:0]  o_core_message,
   input  logic [DIGEST_W-1:0] i_core_digest,
   input  logic                i_core_finish
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

   sched_state_e        r_state, w_state_next;
   logic [ID_W-1:0]     r_ptr;
   logic [ID_W-1:0]     r_id;
   logic [BLOCK_W-1:0]  r_msg;
   logic [DIGEST_W-1:0] r_digest;
   logic                r_error;
   logic [CNT_W-1:0]    r_cnt;

   logic [NUM_REQ-1:0]  w_grant;
   logic [ID_W-1:0]     w_winner;
   logic [ID_W-1:0]     w_ptr_next;
   logic                w_any;
   logic                w_accept;
   logic [CNT_W-1:0]    w_cnt_inc;
   logic                w_timeout;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_arb (
      .i_req      (io_bus.req_valid),
      .i_ptr      (r_ptr),
      .o_grant    (w_grant),
      .o_winner   (w_winner),
      .o_valid    (w_any),
      .o_ptr_next (w_ptr_next)
   );

   // Timeout fires on the WAIT cycle whose incremented count reaches TIMEOUT.
   assign w_cnt_inc = r_cnt + 1'b1;
   assign w_timeout = (w_cnt_inc == CNT_W'(TIMEOUT));

   always_comb begin
      w_state_next = r_state;
      w_accept     = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (w_any && !i_reset) begin
               w_accept     = 1'b1;
               w_state_next = StClear;
            end
         end
         StClear: w_state_next = StRun;
         StRun:   w_state_next = StWait;
         StWait: begin
            if (i_core_finish || w_timeout) begin
               w_state_next = StResp;
            end
         end
         StResp: begin
            if (io_bus.rsp_ready) begin
               w_state_next = StIdle;
            end
         end
         default: w_state_next = StIdle;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_ptr    <= '0;
         r_id     <= '0;
         r_msg    <= '0;
         r_digest <= '0;
         r_error  <= 1'b0;
         r_cnt    <= '0;
      end else begin
         if (w_accept) begin
            r_msg <= io_bus.req_message[BLOCK_W*w_winner +: BLOCK_W];
            r_id  <= w_winner;
            r_ptr <= w_ptr_next;
         end
         if (r_state == StClear) begin
            r_cnt <= '0;
         end
         if (r_state == StWait) begin
            r_cnt <= w_cnt_inc;
            if (i_core_finish) begin
               r_digest <= i_core_digest;
               r_error  <= 1'b0;
            end else if (w_timeout) begin
               r_digest <= '0;
               r_error  <= 1'b1;
            end
         end
      end
   end

   assign io_bus.req_ready  = (r_state == StIdle && !i_reset) ? w_grant : '0;
   assign io_bus.rsp_valid  = (r_state == StResp);
   assign io_bus.rsp_id     = r_id;
   assign io_bus.rsp_digest = r_digest;
   assign io_bus.rsp_error  = r_error;

   assign o_busy         = (r_state != StIdle);
   assign o_core_reset   = i_reset || (r_state == StClear);
   assign o_core_on      = (r_state == StRun) || (r_state == StWait);
   assign o_core_message = r_msg;

endmodule

// File: tb/tb_sha1_scheduler.sv
// Directed bench for sha1_scheduler with a behavioural sha1 core stub.
module tb_sha1_scheduler;

   logic         clk = 1'b0;
   logic         reset;
   logic         busy;
   logic         core_reset;
   logic         core_on;
   logic [511:0] core_message;
   logic [159:0] core_digest;
   logic         core_finish;

   int           stub_n;
   int           stub_cnt;
   logic [159:0] stub_digest;

   int           n_checks = 0;
   int           n_fail   = 0;
   logic         twohot   = 1'b0;
   int           lat;

   localparam logic [511:0] BLK0 = {32'h61626380, 448'h0, 32'h00000018};
   localparam logic [511:0] BLK1 = {32'h64656680, 448'h0, 32'h00000018};
   localparam logic [159:0] D1 = 160'hA9993E36_4706816A_BA3E2571_7850C26C_9CD0D89D;
   localparam logic [159:0] D2 = 160'h01234567_89ABCDEF_FEDCBA98_76543210_F0E1D2C3;

   always #5 clk = ~clk;

   sha1_scheduler_if #(.NUM_REQ(2), .ID_W(1)) bus ();

   sha1_scheduler #(
      .NUM_REQ (2),
      .ID_W    (1),
      .TIMEOUT (511)
   ) dut (
      .i_clk          (clk),
      .i_reset        (reset),
      .io_bus         (bus),
      .o_busy         (busy),
      .o_core_reset   (core_reset),
      .o_core_on      (core_on),
      .o_core_message (core_message),
      .i_core_digest  (core_digest),
      .i_core_finish  (core_finish)
   );

   // Core stub: finish rises stub_n cycles after core_on first goes high; 0 = never.
   always @(posedge clk) begin
      if (core_reset || !core_on) stub_cnt <= 0;
      else                        stub_cnt <= stub_cnt + 1;
   end
   assign core_finish = core_on && (stub_n != 0) && (stub_cnt == stub_n);
   assign core_digest = stub_digest;

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_rsp(input int bound, output int cycles);
      cycles = 0;
      do begin
         @(negedge clk);
         cycles++;
         if ($countones(bus.req_ready) > 1) twohot = 1'b1;
      end while (!bus.rsp_valid && cycles < bound);
   endtask

   initial begin
      reset           = 1'b1;
      bus.req_valid   = 2'b00;
      bus.req_message = {BLK1, BLK0};
      bus.rsp_ready   = 1'b0;
      stub_n          = 250;
      stub_digest     = D1;
      repeat (2) @(negedge clk);
      chk("reset_ctl", {busy, bus.rsp_valid, core_reset, core_on, bus.req_ready, bus.rsp_error},
          {1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0});
      chk("reset_msg", core_message, '0);
      chk("reset_dig", bus.rsp_digest, '0);

      // Single request from requester 0
      reset = 1'b0;
      @(negedge clk);
      bus.req_valid = 2'b01;
      #1;
      chk("t1_grant", bus.req_ready, 2'b01);
      @(negedge clk);
      chk("t1_clear", {core_reset, core_on, bus.req_ready, busy}, {1'b1, 1'b0, 2'b00, 1'b1});
      chk("t1_msg", core_message, BLK0);
      bus.req_valid = 2'b00;
      @(negedge clk);
      chk("t1_run", {core_reset, core_on}, {1'b0, 1'b1});
      wait_rsp(300, lat);
      chk("t1_lat", lat, 251);
      chk("t1_rsp", {bus.rsp_valid, bus.rsp_id, bus.rsp_error}, {1'b1, 1'b0, 1'b0});
      chk("t1_dig", bus.rsp_digest, D1);
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      chk("t1_done", {bus.rsp_valid, busy}, 2'b00);
      bus.rsp_ready = 1'b0;

      // Realign the pointer, then both requesters continuously valid
      reset = 1'b1;
      @(negedge clk);
      reset         = 1'b0;
      bus.req_valid = 2'b11;
      bus.rsp_ready = 1'b1;
      stub_n        = 5;
      stub_digest   = D2;
      for (int j = 0; j < 4; j++) begin
         wait_rsp(60, lat);
         chk("t2_lat", lat, (j == 0) ? 8 : 9);
         chk("t2_id", bus.rsp_id, j % 2);
         chk("t2_msg", core_message, (j % 2 == 1) ? BLK1 : BLK0);
         chk("t2_dig", bus.rsp_digest, D2);
         if (j == 3) bus.req_valid = 2'b00;
      end
      chk("t2_twohot", twohot, 1'b0);

      // Core never finishes: timeout response for requester 1
      @(negedge clk);
      bus.req_valid = 2'b10;
      bus.rsp_ready = 1'b0;
      stub_n        = 0;
      wait_rsp(600, lat);
      chk("t3_lat", lat, 514);
      chk("t3_rsp", {bus.rsp_valid, bus.rsp_id, bus.rsp_error}, {1'b1, 1'b1, 1'b1});
      chk("t3_dig", bus.rsp_digest, '0);

      // Back-pressure: response held, no grants while busy
      bus.req_valid = 2'b11;
      stub_n        = 5;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         chk("t4_hold", {bus.rsp_valid, bus.rsp_error, bus.rsp_id, bus.req_ready, busy,
                         bus.rsp_digest}, {1'b1, 1'b1, 1'b1, 2'b00, 1'b1, 160'h0});
      end
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      chk("t4_regrant", {busy, bus.req_ready}, {1'b0, 2'b01});
      @(negedge clk);
      bus.req_valid = 2'b00;
      wait_rsp(60, lat);
      chk("t4_rsp", {bus.rsp_id, bus.rsp_error}, 2'b00);
      chk("t4_dig", bus.rsp_digest, D2);

      // Reset during WAIT drops the job and returns the pointer to 0
      @(negedge clk);
      bus.req_valid = 2'b01;
      stub_n        = 0;
      @(negedge clk);
      bus.req_valid = 2'b00;
      repeat (10) @(negedge clk);
      chk("t5_wait", {busy, core_on}, 2'b11);
      reset = 1'b1;
      @(negedge clk);
      chk("t5_reset", {busy, bus.rsp_valid, core_reset, core_on, bus.req_ready},
          {1'b0, 1'b0, 1'b1, 1'b0, 2'b00});
      reset         = 1'b0;
      bus.req_valid = 2'b11;
      stub_n        = 5;
      #1;
      chk("t5_ptr0", bus.req_ready, 2'b01);
      @(negedge clk);
      bus.req_valid = 2'b00;
      wait_rsp(60, lat);
      chk("t5_rsp", {bus.rsp_valid, bus.rsp_id, bus.rsp_error}, {1'b1, 1'b0, 1'b0});

      // Finish on the same cycle the timeout would fire
      @(negedge clk);
      bus.req_valid = 2'b10;
      stub_n        = 511;
      stub_digest   = D1;
      wait_rsp(600, lat);
      chk("t6_lat", lat, 514);
      chk("t6_rsp", {bus.rsp_valid, bus.rsp_id, bus.rsp_error}, {1'b1, 1'b1, 1'b0});
      chk("t6_dig", bus.rsp_digest, D1);
      bus.req_valid = 2'b00;
      @(negedge clk);
      chk("t6_idle", {busy, bus.rsp_valid}, 2'b00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
